// File: rtl/demux8_32_buf.sv
// Registered 1-to-8 demultiplexer for 32-bit words with one single-entry
// buffer per output lane and an independent valid/ready handshake per lane.
// Optional feature macro: DEMUX8_STALL_CNT_EN enables a saturating counter of
// back-pressured input cycles on stall_cnt; without it stall_cnt is tied to 0.
module demux8_32_buf (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_sel,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic [255:0] out_data,
  output logic [31:0]  stall_cnt
);

  logic [7:0]  valid_q;
  logic [31:0] data_q [8];
  logic        in_fire;
  logic [7:0]  load;
  logic [7:0]  drain;

  // Handshake decode: readiness depends only on the addressed lane.
  always_comb begin
    in_ready = !valid_q[in_sel] || out_ready[in_sel];
    in_fire  = in_valid && in_ready;
    load     = in_fire ? (8'(1) << in_sel) : 8'h00;
    drain    = valid_q & out_ready;
  end

  // Lane valid flags: a load wins over a drain, giving pass-through refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 8'h00;
    end else begin
      valid_q <= (valid_q & ~drain) | load;
    end
  end

  // Lane data registers: load on accept, otherwise hold (even when drained).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= 32'h0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (load[k]) begin
          data_q[k] <= in_data;
        end
      end
    end
  end

  // Output packing: lane k word on bits [32k+31:32k].
  always_comb begin
    out_valid = valid_q;
    out_data  = '0;
    for (int k = 0; k < 8; k++) begin
      out_data[32*k +: 32] = data_q[k];
    end
  end

`ifdef DEMUX8_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count cycles where upstream offers a word that cannot be taken; saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'h0;
    end else if (in_valid && !in_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_demux8_32_buf.sv
// Self-checking bench for demux8_32_buf: constant vector table, directed
// corner-case sequences and a randomized run against a queue-based model.
module tb_demux8_32_buf;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_sel;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [255:0] out_data;
  logic [31:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  demux8_32_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each lane is a FIFO of capacity one plus the last word
  // ever written to it (the register keeps it after draining).
  logic [31:0] lane_q [8][$];
  logic [31:0] last_word [8];
  longint      m_stall;
  logic        rdy_seen;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      lane_q[k].delete();
      last_word[k] = 32'h0;
    end
    m_stall = 0;
  endtask

  function automatic logic [7:0] m_valid();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = (lane_q[k].size() != 0);
    return v;
  endfunction

  function automatic logic [255:0] m_data();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = last_word[k];
    return d;
  endfunction

  // Called just after a falling edge: drive inputs, check in_ready, clock
  // once, advance the model, check all outputs at the next falling edge.
  task automatic step(input logic v, input logic [2:0] sel, input logic [31:0] data,
                      input logic [7:0] ordy);
    logic exp_rdy;
    in_valid  = v;
    in_sel    = sel;
    in_data   = data;
    out_ready = ordy;
    #1;
    exp_rdy  = (lane_q[sel].size() == 0) || ordy[sel];
    rdy_seen = in_ready;
    chk("in_ready", 256'(in_ready), 256'(exp_rdy));
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      if (ordy[k] && lane_q[k].size() != 0) void'(lane_q[k].pop_front());
    end
    if (v && exp_rdy) begin
      lane_q[sel].push_back(data);
      last_word[sel] = data;
    end
`ifdef DEMUX8_STALL_CNT_EN
    if (v && !exp_rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
`endif
    @(negedge clk);
    chk("out_valid", 256'(out_valid), 256'(m_valid()));
    chk("out_data", out_data, m_data());
    chk("stall_cnt", 256'(stall_cnt), 256'(m_stall));
  endtask

  // Reset with the clock running; checks take effect without any clock edge.
  task automatic do_reset();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst out_valid", 256'(out_valid), 256'(8'h00));
    chk("rst stall_cnt", 256'(stall_cnt), 256'(32'h0));
    chk("rst out_data", out_data, 256'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic [31:0] data;
    logic [7:0]  ordy;
    logic        exp_rdy;
    logic [7:0]  exp_vld;
    logic [31:0] exp_word;
  } vec_t;

  vec_t tbl [8];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    in_data   = 32'h0;
    out_ready = 8'h00;
    model_clear();

    // Table rows run from reset; exp_word is the selected lane after the edge.
    tbl[0] = '{1'b1, 3'd6, 32'hDEADBEEF, 8'h00, 1'b1, 8'h40, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 3'd6, 32'h0000_0001, 8'h00, 1'b0, 8'h40, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 3'd6, 32'h0000_0002, 8'h40, 1'b1, 8'h00, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 3'd3, 32'h0000_0033, 8'h00, 1'b1, 8'h08, 32'h0000_0033};
    tbl[4] = '{1'b1, 3'd1, 32'h0000_0011, 8'h00, 1'b1, 8'h0A, 32'h0000_0011};
    tbl[5] = '{1'b1, 3'd1, 32'h0000_0022, 8'h02, 1'b1, 8'h0A, 32'h0000_0022};
    tbl[6] = '{1'b1, 3'd3, 32'h0000_0044, 8'h00, 1'b0, 8'h0A, 32'h0000_0033};
    tbl[7] = '{1'b0, 3'd0, 32'h0000_0099, 8'hFF, 1'b1, 8'h00, 32'h0000_0000};

    #1;
    chk("reset in_ready", 256'(in_ready), 256'(1'b1));
    chk("reset out_valid", 256'(out_valid), 256'(8'h00));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset stall_cnt", 256'(stall_cnt), 256'(32'h0));
    chk("reset out_data", out_data, 256'h0);

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].ordy);
      chk($sformatf("tbl%0d in_ready", i), 256'(rdy_seen), 256'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d out_valid", i), 256'(out_valid), 256'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d word", i), 256'(out_data[32*tbl[i].sel +: 32]),
          256'(tbl[i].exp_word));
    end

    // Back-pressure: lane 3 full and its consumer stalled for 4 cycles.
    do_reset();
    step(1'b1, 3'd3, 32'h3333_0000, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'd3, 32'h3333_0001, 8'h00);
      chk("bp in_ready", 256'(rdy_seen), 256'(1'b0));
    end
`ifdef DEMUX8_STALL_CNT_EN
    chk("bp stall_cnt", 256'(stall_cnt), 256'(32'd4));
`else
    chk("bp stall_cnt", 256'(stall_cnt), 256'(32'd0));
`endif
    chk("bp lane3", 256'(out_data[127:96]), 256'(32'h3333_0000));

    // Lane isolation: lane 0 stalled full while lanes 7 and 4 stream.
    do_reset();
    step(1'b1, 3'd0, 32'h0000_0055, 8'h00);
    step(1'b1, 3'd7, 32'h0000_000A, 8'h90);
    chk("iso A accepted", 256'(rdy_seen), 256'(1'b1));
    step(1'b1, 3'd4, 32'h0000_000B, 8'h90);
    chk("iso B accepted", 256'(rdy_seen), 256'(1'b1));
    step(1'b1, 3'd7, 32'h0000_000C, 8'h90);
    chk("iso C accepted", 256'(rdy_seen), 256'(1'b1));
    chk("iso lane7", 256'(out_data[255:224]), 256'(32'h0000_000C));
    chk("iso lane0", 256'(out_data[31:0]), 256'(32'h0000_0055));
    chk("iso lane0 valid", 256'(out_valid[0]), 256'(1'b1));

    // Mid-run reset with lanes 2 and 5 full, then in_ready after release.
    step(1'b1, 3'd2, 32'h2222_2222, 8'h00);
    step(1'b1, 3'd5, 32'h5555_5555, 8'h00);
    chk("pre-rst valid", 256'(out_valid & 8'h24), 256'(8'h24));
    do_reset();
    in_valid = 1'b1;
    in_sel   = 3'd2;
    #1;
    chk("post-rst in_ready", 256'(in_ready), 256'(1'b1));
    in_valid = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom), $urandom,
           8'($urandom) & 8'($urandom));
    end

`ifdef DEMUX8_STALL_CNT_EN
    // Saturation: preload the counter just below the top, then stall 3 cycles.
    do_reset();
    step(1'b1, 3'd3, 32'h0000_0003, 8'h00);
    force dut.stall_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_q;
    m_stall = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd3, 32'h0000_0004, 8'h00);
    end
    chk("sat stall_cnt", 256'(stall_cnt), 256'(32'hFFFF_FFFF));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux8_32_buf.md
# demux8_32_buf

Registered 1-to-8 demultiplexer for 32-bit words, the distribution counterpart of the 8-input word selector. A single upstream producer, such as the pipeline writeback or a bus response, presents a word with a 3-bit destination index. The block steers that word into one of eight single-entry output buffers. Each lane has an independent valid/ready handshake, so a stalled consumer blocks only traffic addressed to its own lane.

## Interface
- No parameters. Data width is fixed at 32 and lane count at 8.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word present
- in_ready  output  1  block accepts the word this cycle
- in_data  input  32  word to route
- in_sel  input  3  destination lane, 0..7
- out_valid  output  8  bit k: lane k buffer holds a word
- out_ready  input  8  bit k: lane k consumer takes the word this cycle
- out_data  output  256  lane k word on bits [32k+31:32k]
- stall_cnt  output  32  saturating count of back-pressured input cycles (see Configuration)

## Operation
- Each lane k holds:
  - a 32-bit data register, which drives out_data[32k+31:32k] directly;
  - a valid flag, which drives out_valid[k].
- The input transfer fires when in_valid && in_ready.
- The lane k transfer fires when out_valid[k] && out_ready[k].
- in_ready = !out_valid[in_sel] || out_ready[in_sel]. This is combinational.
  - in_ready depends only on the selected lane.
  - in_ready does not depend on in_valid.
- Lane k update on each clock edge:
  - If the input fires and in_sel == k: the data register loads in_data and the valid flag is set to 1.
    - This applies even if lane k is also firing on its output in the same cycle (pass-through refill).
  - Otherwise, if lane k fires on its output: the valid flag is cleared to 0 and the data register holds its value.
  - Otherwise: the lane is unchanged.
- Lanes are independent. Any number of lanes may drain in the same cycle an input fires into another lane.
- The data register of a non-valid lane is don't-care to consumers. It retains its last value and is not cleared.
- in_sel and in_data are ignored when in_valid = 0.
- No word is ever dropped, duplicated, or reordered within a lane.

## Timing
- Reset (asynchronous assert, clean release on clk):
  - out_valid = 8'h00;
  - all lane data registers = 0;
  - stall_cnt = 0.
- While rst_n = 0, in_ready = 1. No transfer is recorded until rst_n releases.
- Latency: a word accepted at edge N appears with out_valid[k] = 1 immediately after edge N. This is one cycle of latency.
- Throughput to one lane:
  - 1 word/cycle if its consumer holds out_ready[k] = 1;
  - 1 word per consumer acceptance otherwise.
- Full lane: with out_valid[k] = 1 and out_ready[k] = 0, in_ready = 0 for in_sel = k. The upstream must hold in_data and in_sel stable until acceptance.
- Reset asserted mid-operation: every buffered word is discarded and out_valid goes to 0 asynchronously.

## Configuration
- Macro: DEMUX8_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on every cycle with in_valid = 1 and in_ready = 0;
  - it saturates at 32'hFFFF_FFFF and never wraps;
  - it is cleared only by reset.
- Undefined: stall_cnt is constant 0 and no counter logic is synthesized.
- The port exists in both builds.

## Test plan
- Reset:
  - Assert rst_n = 0 mid-run with lanes 2 and 5 full.
  - Required: out_valid = 0x00 and stall_cnt = 0 with no clock edge.
  - Required after release: in_ready = 1.
- Single route:
  - Drive in_sel = 6, in_data = 0xDEADBEEF, in_valid = 1 for one cycle, with out_ready = 0.
  - Required next cycle: out_valid = 0x40 and out_data[223:192] = 0xDEADBEEF.
- Back-pressure:
  - With lane 3 full and out_ready[3] = 0, present in_sel = 3 for 4 cycles.
  - Required: in_ready = 0 throughout.
  - Required, macro defined: stall_cnt = 4.
  - Required, macro undefined: stall_cnt = 0.
- Pass-through refill:
  - Lane 1 holds 0x11. Present in_sel = 1, data 0x22, with out_ready[1] = 1.
  - Required: in_ready = 1.
  - Required next cycle: lane 1 = 0x22 and out_valid[1] = 1.
- Lane isolation:
  - Lane 0 is stalled full.
  - Stream in_sel = 7, 4, 7 with data 0xA, 0xB, 0xC, with out_ready[7] = out_ready[4] = 1.
  - Required: all accepted back-to-back.
  - Required: lane 0 word unchanged.
- Saturation (macro defined):
  - Force stall_cnt near 32'hFFFF_FFFE and stall 3 cycles.
  - Required: the count holds at 32'hFFFF_FFFF.
